// File: rtl/tbec_memory_pkg.sv
// ---------------------------------------------------------------------------
// tbec_memory_pkg
//
// Shared definitions for the TBEC scratch memory and its parity helper.
//   ADDR_WIDTH_DEFAULT / DATA_WIDTH_DEFAULT : default geometry (256 x 32)
//   addr_t / word_t                         : address and data word types
//   even_parity()                           : XOR-reduce of a data word
// ---------------------------------------------------------------------------
package tbec_memory_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 8;
  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef logic [ADDR_WIDTH_DEFAULT-1:0] addr_t;
  typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;

  // Even parity bit: the value that makes the total count of ones even.
  function automatic logic even_parity(input word_t word);
    return ^word;
  endfunction

endpackage : tbec_memory_pkg

// File: rtl/tbec_parity_gen.sv
// ---------------------------------------------------------------------------
// tbec_parity_gen
//
// Combinational even-parity generator (XOR-reduce of one word).
// Only used by tbec_memory when TBEC_MEMORY_PARITY_EN is defined, so the
// module is only compiled in that configuration.
//
// Ports:
//   word   : input  [WIDTH-1:0]  word to reduce
//   parity : output              XOR of all bits of word
// ---------------------------------------------------------------------------
`ifdef TBEC_MEMORY_PARITY_EN
module tbec_parity_gen
  import tbec_memory_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] word,
  output logic             parity
);

  assign parity = ^word;

endmodule : tbec_parity_gen
`endif

// File: rtl/tbec_memory.sv
// ---------------------------------------------------------------------------
// tbec_memory
//
// Single-port 2**ADDR_WIDTH x DATA_WIDTH scratch memory for the TBEC ECC
// datapath. Writes are synchronous, reads are combinational, and a
// synchronous active-high reset clears every word. Storage is built from
// flops (not a RAM macro) so that the reset can clear the whole array.
//
// Optional feature (macro TBEC_MEMORY_PARITY_EN):
//   Each word carries one stored even-parity bit. parity_err flags a
//   mismatch between the stored word at addr and its parity bit; inj_err
//   stores an inverted parity bit during a write to inject an error.
//
// Ports:
//   clk        : input                  system clock, rising edge
//   rst        : input                  synchronous active-high reset
//   we         : input                  write enable
//   addr       : input  [ADDR_WIDTH-1:0] read/write word address
//   data_in    : input  [DATA_WIDTH-1:0] write data
//   data_out   : output [DATA_WIDTH-1:0] stored word at addr (combinational)
//   inj_err    : input                  (parity build) invert stored parity
//   parity_err : output                 (parity build) parity check failed
// ---------------------------------------------------------------------------
module tbec_memory
  import tbec_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef TBEC_MEMORY_PARITY_EN
  ,
  input  logic                  inj_err,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset wins over a same-cycle write. A non-1 we (0 or unknown) leaves the
  // array untouched, so an undriven enable cannot disturb stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= data_in;
    end
  end

  // No write-through bypass: a same-address write shows up only after the edge.
  assign data_out = mem[addr];

`ifdef TBEC_MEMORY_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_parity;
  logic rd_parity;

  tbec_parity_gen #(
    .WIDTH (DATA_WIDTH)
  ) u_wr_parity (
    .word   (data_in),
    .parity (wr_parity)
  );

  tbec_parity_gen #(
    .WIDTH (DATA_WIDTH)
  ) u_rd_parity (
    .word   (data_out),
    .parity (rd_parity)
  );

  // Cleared parity (0) matches cleared data (parity of zero is 0), so no
  // error is flagged after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_mem[i] <= 1'b0;
      end
    end else if (we) begin
      par_mem[addr] <= wr_parity ^ inj_err;
    end
  end

  assign parity_err = rd_parity ^ par_mem[addr];
`endif

endmodule : tbec_memory

// File: tb/tb_tbec_memory.sv
// ---------------------------------------------------------------------------
// tb_tbec_memory
//
// Self-checking bench for tbec_memory. A reference array of words (plus
// parity bits when TBEC_MEMORY_PARITY_EN is defined) mirrors what the
// memory should hold; each scenario task drives the DUT and compares its
// outputs against that reference.
// ---------------------------------------------------------------------------
module tb_tbec_memory;
  import tbec_memory_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH_DEFAULT;

  logic  clk;
  logic  rst;
  logic  we;
  addr_t addr;
  word_t data_in;
  word_t data_out;
`ifdef TBEC_MEMORY_PARITY_EN
  logic  inj_err;
  logic  parity_err;
`endif

  int compared;
  int mismatched;

  // Reference contents: what each address should read back.
  word_t ref_mem [DEPTH];
  logic  ref_par [DEPTH];

  tbec_memory dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out)
`ifdef TBEC_MEMORY_PARITY_EN
    ,
    .inj_err    (inj_err),
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model helpers (stimulus and bookkeeping only, no checking).
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_par[i] = 1'b0;
    end
  endtask

  // Drive one write for the next rising edge and record it in the model.
  task automatic drive_write(input addr_t a, input word_t d, input logic inj);
    @(negedge clk);
    we      = 1'b1;
    addr    = a;
    data_in = d;
`ifdef TBEC_MEMORY_PARITY_EN
    inj_err = inj;
`endif
    @(posedge clk);
    ref_mem[a] = d;
    ref_par[a] = even_parity(d) ^ inj;
  endtask

  task automatic go_idle();
    @(negedge clk);
    we = 1'b0;
`ifdef TBEC_MEMORY_PARITY_EN
    inj_err = 1'b0;
`endif
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    addr_t probe [4];
    probe[0] = 8'h00; probe[1] = 8'h01; probe[2] = 8'hFF; probe[3] = addr_t'($urandom_range(2, 254));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = probe[i];
      #1;
      compared++;
      if (data_out !== 32'h0000_0000) begin
        mismatched++;
        $display("[TB] FAIL reset_read addr=%h: got %h, expected 00000000", probe[i], data_out);
      end
`ifdef TBEC_MEMORY_PARITY_EN
      compared++;
      if (parity_err !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_parity addr=%h: got %b, expected 0", probe[i], parity_err);
      end
`endif
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    addr_t a_tab [4];
    word_t d_tab [4];
    a_tab[0] = 8'h01; a_tab[1] = 8'h02; a_tab[2] = 8'h07; a_tab[3] = 8'h03;
    d_tab[0] = 32'hAABBCCDD; d_tab[1] = 32'hBBCCDDEE; d_tab[2] = 32'hFFAABBCC; d_tab[3] = 32'h0;
    for (int i = 0; i < 3; i++) drive_write(a_tab[i], d_tab[i], 1'b0);
    go_idle();
    for (int i = 0; i < 4; i++) begin
      addr = a_tab[i];
      #1;
      compared++;
      if (data_out !== d_tab[i]) begin
        mismatched++;
        $display("[TB] FAIL b2b_read addr=%h: got %h, expected %h", a_tab[i], data_out, d_tab[i]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_read_during_write();
    @(negedge clk);
    we      = 1'b1;
    addr    = 8'h05;
    data_in = 32'h12345678;
    #1;
    compared++;
    if (data_out !== 32'h0000_0000) begin
      mismatched++;
      $display("[TB] FAIL rdw_before: got %h, expected 00000000", data_out);
    end
    @(posedge clk);
    ref_mem[8'h05] = 32'h12345678;
    ref_par[8'h05] = even_parity(32'h12345678);
    #1;
    compared++;
    if (data_out !== 32'h12345678) begin
      mismatched++;
      $display("[TB] FAIL rdw_after: got %h, expected 12345678", data_out);
    end
    go_idle();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_priority();
    addr_t probe [4];
    probe[0] = 8'hFF; probe[1] = 8'h10; probe[2] = 8'h01; probe[3] = 8'h05;
    drive_write(8'hFF, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    rst     = 1'b1;
    we      = 1'b1;
    addr    = 8'h10;
    data_in = 32'h11111111;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = probe[i];
      #1;
      compared++;
      if (data_out !== 32'h0000_0000) begin
        mismatched++;
        $display("[TB] FAIL rst_prio addr=%h: got %h, expected 00000000", probe[i], data_out);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_overwrite();
    addr_t probe [3];
    word_t expect_tab [3];
    probe[0] = 8'h20; probe[1] = 8'h1F; probe[2] = 8'h21;
    expect_tab[0] = 32'h0BADF00D; expect_tab[1] = 32'h0; expect_tab[2] = 32'h0;
    drive_write(8'h20, 32'hCAFEF00D, 1'b0);
    drive_write(8'h20, 32'h0BADF00D, 1'b0);
    go_idle();
    for (int i = 0; i < 3; i++) begin
      addr = probe[i];
      #1;
      compared++;
      if (data_out !== expect_tab[i]) begin
        mismatched++;
        $display("[TB] FAIL overwrite addr=%h: got %h, expected %h", probe[i], data_out, expect_tab[i]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Unknown write enable must not disturb any other address.
  task automatic test_unknown_we();
    drive_write(8'h40, 32'h40404040, 1'b0);
    drive_write(8'h41, 32'h41414141, 1'b0);
    @(negedge clk);
    we      = 1'bx;
    addr    = 8'h40;
    data_in = 32'h99999999;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    addr = 8'h41;
    #1;
    compared++;
    if (data_out !== ref_mem[8'h41]) begin
      mismatched++;
      $display("[TB] FAIL x_we_neighbour: got %h, expected %h", data_out, ref_mem[8'h41]);
    end
    // Address 0x40 is indeterminate now; put it back to a known value.
    drive_write(8'h40, 32'h40404040, 1'b0);
    go_idle();
  endtask

  // -------------------------------------------------------------------------
  // Random mix of reads and writes. Before each edge the output must show
  // the model's current contents; writes land in the model after the edge.
  task automatic test_random();
    addr_t a;
    word_t d;
    logic  w;
    logic  inj;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a   = addr_t'($urandom_range(0, DEPTH - 1));
      // Bias towards a small window so reads often hit written words.
      if ($urandom_range(0, 1) == 1) a = addr_t'($urandom_range(0, 15));
      d   = word_t'($urandom);
      w   = ($urandom_range(0, 2) != 0);
      inj = ($urandom_range(0, 7) == 0);
      we      = w;
      addr    = a;
      data_in = d;
`ifdef TBEC_MEMORY_PARITY_EN
      inj_err = inj;
`endif
      #1;
      compared++;
      if (data_out !== ref_mem[a]) begin
        mismatched++;
        $display("[TB] FAIL random_read n=%0d addr=%h: got %h, expected %h", n, a, data_out, ref_mem[a]);
      end
`ifdef TBEC_MEMORY_PARITY_EN
      compared++;
      if (parity_err !== (even_parity(ref_mem[a]) != ref_par[a])) begin
        mismatched++;
        $display("[TB] FAIL random_parity n=%0d addr=%h: got %b, expected %b", n, a, parity_err,
                 even_parity(ref_mem[a]) != ref_par[a]);
      end
`endif
      @(posedge clk);
      if (w) begin
        ref_mem[a] = d;
        ref_par[a] = even_parity(d) ^ inj;
      end
    end
    go_idle();
  endtask

`ifdef TBEC_MEMORY_PARITY_EN
  // -------------------------------------------------------------------------
  task automatic test_parity();
    drive_write(8'h30, 32'h00000001, 1'b0);
    go_idle();
    addr = 8'h30;
    #1;
    compared++;
    if (parity_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL parity_clean: got %b, expected 0", parity_err);
    end
    drive_write(8'h30, 32'h00000001, 1'b1);
    go_idle();
    addr = 8'h30;
    #1;
    compared++;
    if (parity_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL parity_injected: got %b, expected 1", parity_err);
    end
    compared++;
    if (data_out !== 32'h00000001) begin
      mismatched++;
      $display("[TB] FAIL parity_data: got %h, expected 00000001", data_out);
    end
    addr = 8'h31;
    #1;
    compared++;
    if (parity_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL parity_neighbour: got %b, expected 0", parity_err);
    end
  endtask
`endif

  // -------------------------------------------------------------------------
  initial begin
    compared   = 0;
    mismatched = 0;
    rst     = 1'b1;
    we      = 1'b0;
    addr    = '0;
    data_in = '0;
`ifdef TBEC_MEMORY_PARITY_EN
    inj_err = 1'b0;
`endif
    model_clear();

    test_reset();
    test_back_to_back();
    test_read_during_write();
    test_reset_priority();
    test_overwrite();
    test_unknown_we();
    test_random();
`ifdef TBEC_MEMORY_PARITY_EN
    test_parity();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_tbec_memory
